// File: rtl/dmem_responder.sv
// dmem_responder
// Data-memory responder for the MEM stage. It accepts one MemRead/MemWrite
// request at a time and answers it after WAIT_CYCLES wait states. While an
// access is in flight, busy stalls the pipeline.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (aborts any access in flight)
//   mem_read   read request
//   mem_write  write request (wins when both requests are set)
//   addr       byte address; word index = addr[log2(DEPTH_WORDS)+1:2]
//   wdata      store data
//   rdata      load data, registered; changes only when a read completes
//   ready      one-cycle completion strobe
//   busy       stall request (combinational)
//   err        misaligned-access flag, valid with ready
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   When this macro is defined, a misaligned access still completes with
//   normal timing, but it raises err. A misaligned write is dropped, and a
//   misaligned read returns zero. When the macro is undefined, err is tied
//   low and addr[1:0] is ignored.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             op_write_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             ready_q;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic             req_s;
  logic             accept_s;
  logic             enter_resp_s;
  logic             acc_write_s;
  logic [IDX_W-1:0] acc_idx_s;
  logic [31:0]      acc_wdata_s;
  logic             acc_mis_s;
  logic             unused_s;

  assign req_s        = mem_read | mem_write;
  assign accept_s     = (state_q == ST_IDLE) && req_s;
  assign enter_resp_s = (state_d == ST_RESP);

  // With zero wait states, RESP is entered directly from IDLE. In that case
  // the latched operands do not exist yet, so the access uses the live inputs.
  assign acc_write_s = (state_q == ST_IDLE) ? mem_write           : op_write_q;
  assign acc_idx_s   = (state_q == ST_IDLE) ? addr[IDX_W+1:2]     : idx_q;
  assign acc_wdata_s = (state_q == ST_IDLE) ? wdata               : wdata_q;

`ifdef DMEM_ALIGN_CHECK_EN
  logic mis_q;
  logic err_q;
  assign acc_mis_s = (state_q == ST_IDLE) ? (addr[1:0] != 2'b00) : mis_q;
`else
  assign acc_mis_s = 1'b0;
`endif

  // The upper address bits alias modulo the depth, so they are intentionally unused.
  assign unused_s = ^{addr[31:IDX_W+2], addr[1:0]};

  // State register and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Operand latch. Operands are captured only on accept; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
`ifdef DMEM_ALIGN_CHECK_EN
      mis_q      <= 1'b0;
`endif
    end else if (accept_s) begin
      op_write_q <= mem_write;
      idx_q      <= addr[IDX_W+1:2];
      wdata_q    <= wdata;
`ifdef DMEM_ALIGN_CHECK_EN
      mis_q      <= (addr[1:0] != 2'b00);
`endif
    end
  end

  // Storage array; it is never cleared. The write is gated by rst so that an aborted access cannot commit.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp_s && acc_write_s && !acc_mis_s) begin
      mem_q[acc_idx_s] <= acc_wdata_s;
    end
  end

  // Response registers, loaded on the edge that enters RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      ready_q <= enter_resp_s;
`ifdef DMEM_ALIGN_CHECK_EN
      err_q   <= enter_resp_s && acc_mis_s;
`endif
      if (enter_resp_s && !acc_write_s) begin
        rdata_q <= acc_mis_s ? 32'd0 : mem_q[acc_idx_s];
      end
    end
  end

  // Output logic. busy covers the accept cycle plus all wait states.
  always_comb begin
    busy  = ((state_q == ST_IDLE) && req_s) || (state_q == ST_WAIT);
    rdata = rdata_q;
    ready = ready_q;
`ifdef DMEM_ALIGN_CHECK_EN
    err   = err_q;
`else
    err   = 1'b0;
`endif
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the MEM stage of the 5-stage pipeline: it is the memory side of the MemRead/MemWrite/address/write-data interface that the pipeline drives.
- It answers each request after a programmable number of wait states and holds the pipeline with a busy signal until the access completes.
- Replaces the zero-latency data memory bank, so the core can be exercised against slow memory.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; power of two, 16..4096
WAIT_CYCLES, 2, wait states between accept and response; 0..15

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
mem_read  input  1  read request from MEM stage
mem_write  input  1  write request from MEM stage
addr  input  32  byte address (ALU result)
wdata  input  32  store data
rdata  output  32  load data, registered
ready  output  1  one-cycle response strobe; access complete
busy  output  1  stall request to pipeline; combinational from state and request inputs
err  output  1  misaligned-access flag, valid with ready (feature-dependent)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; rdata=0, ready=0, err=0; wait counter=0.
  - Array contents are not cleared.
  - A request in flight is aborted; a pending write is NOT committed.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so accesses alias (wrap) modulo the depth.
- States: IDLE, WAIT, RESP.
- IDLE:
  - A request is present when mem_read=1 or mem_write=1.
  - On the edge with a request present: latch op, addr, wdata; load counter=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
  - mem_read and mem_write both 1: treated as a write.
- WAIT:
  - Counter decrements each cycle.
  - On the edge where the counter reads 1, go to RESP.
  - Input changes during WAIT are ignored (operands already latched).
- Access timing:
  - The array access is performed on the edge entering RESP.
  - Write: array[idx]<=latched wdata.
  - Read: rdata<=array[idx].
- RESP:
  - Lasts exactly one cycle: ready=1, busy=0.
  - Next state is always IDLE. A request still asserted in the following IDLE cycle is a new request; the pipeline has advanced.
- busy = (IDLE and (mem_read or mem_write)) or WAIT.
  - Request accepted at cycle t: ready at cycle t+1+WAIT_CYCLES; busy high for 1+WAIT_CYCLES cycles.
- ready is 0 in IDLE and WAIT.
- rdata holds its last read value across writes and idle cycles; it changes only when a read completes.
- Read of a word written by the immediately preceding request returns the new data (no forwarding hazard; the accesses are serialized).
- No request in IDLE: nothing changes, busy=0.

Optional Feature:
Macro: DMEM_ALIGN_CHECK_EN
- Defined:
  - A request with addr[1:0]!=0 is accepted and timed normally.
  - In RESP: ready=1, err=1. A write is suppressed (array unchanged); a read sets rdata=0.
  - err is 0 at all other times and for aligned accesses.
- Undefined:
  - addr[1:0] is ignored and the access uses the word index.
  - err is tied to 0.

Test Plan:
- WAIT_CYCLES=2: write addr=0x10, wdata=0xDEADBEEF at cycle 0 -> busy=1 cycles 0-2, ready=1 at cycle 3 only. Then read 0x10 -> rdata=0xDEADBEEF with ready at cycle 7 (3-cycle request, 1 idle gap).
- WAIT_CYCLES=0: back-to-back reads of 0x0 and 0x4 (preloaded 0x11, 0x22) -> ready every second cycle, rdata 0x11 then 0x22, busy only in accept cycles.
- DEPTH_WORDS=256: write 0xA5A5A5A5 to 0x400, read 0x0 -> returns 0xA5A5A5A5 (address wraps).
- Simultaneous mem_read=mem_write=1, addr=0x20, wdata=0x5 -> treated as write; a subsequent read of 0x20 returns 0x5.
- rst pulsed during WAIT of write 0x30=0x77 (WAIT_CYCLES=3) -> ready never asserts, outputs 0, a later read of 0x30 returns its old value.
- DMEM_ALIGN_CHECK_EN: write 0x12 with 0x99 -> ready=1, err=1, word 0x10 unchanged. Without the macro -> err=0 and word 0x10=0x99.
